riscv_core_btb_assoc: RTL
=========================

# riscv_core_btb_assoc

Set-associative branch target buffer with per-entry saturating direction counters, pseudo-LRU replacement and a sequential invalidation sweep. It sits in the fetch stage and is looked up combinationally with the fetch PC; resolved branches from execute update it. It replaces the direct-mapped predictor. Associativity, set count and counter width are configurable, and an optional gshare direction table can be compiled in.

## Interface
- PC_LEN, 64, PC width in bits
- SETS_LOG2, 7, log2 of set count; index = pc[SETS_LOG2:1]
- WAYS, 2, associativity; power of two, 1..8
- TAG_WIDTH, PC_LEN-SETS_LOG2-1, tag = pc[PC_LEN-1:SETS_LOG2+1]
- CNT_BITS, 2, saturating counter width, ≥2

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  start invalidation sweep (fence.i / context switch)
- o_ready  out  1  high when sweep complete and BTB operational
- i_if_pc  in  PC_LEN  fetch PC to look up
- o_hit  out  1  valid tag match in indexed set
- o_target  out  PC_LEN  predicted target; 0 when !o_hit
- o_taken  out  1  predicted direction; 0 when !o_hit
- i_upd_valid  in  1  resolved branch update this cycle
- i_upd_pc  in  PC_LEN  PC of resolved branch
- i_upd_target  in  PC_LEN  resolved target
- i_upd_taken  in  1  resolved direction

## Operation
- Entry: valid, tag, target, CNT_BITS counter. Per set: WAYS-1 bit tree PLRU (none when WAYS=1).
- FSM states INIT, READY. Reset → INIT, sweep counter = 0. INIT: each cycle clear valid bits of all ways and the PLRU of set[counter], reset any direction table rows, counter++. After set 2**SETS_LOG2-1 → READY. o_ready = (state==READY).
- i_flush in READY → INIT with counter 0. i_flush in INIT → counter restarts at 0.
- In INIT: o_hit=0, o_taken=0, o_target=0; updates dropped.
- Lookup (READY): compare tag across all ways of the indexed set. On multiple matches the lowest way wins. o_taken = counter MSB.
- Update hit (way w): overwrite target; counter saturating +1 if taken, -1 otherwise; PLRU touch w.
- Update miss, taken: victim = lowest invalid way, otherwise the PLRU victim. Write valid=1, tag, target, counter = weakly taken (MSB=1, rest 0); PLRU touch victim.
- Update miss, not taken: no allocation, no state change.
- Lookups never change PLRU state.
- Counters are array contents. Only valid bits, PLRU, FSM, sweep counter and GHR are reset, so the arrays can map to SRAM.

## Timing
- Lookup combinational: i_if_pc → o_hit/o_target/o_taken in the same cycle.
- Update written at the posedge where i_upd_valid=1. Visible to lookups from the following cycle. No same-cycle bypass: a lookup in the update cycle sees the old contents.
- Init latency: o_ready rises 2**SETS_LOG2 cycles after reset deassertion or after the i_flush cycle.
- Reset values: o_ready=0, o_hit=0, o_taken=0, o_target=0, state=INIT, GHR=0.
- Reset mid-sweep or mid-operation returns to INIT, counter 0.
- Simultaneous i_flush and i_upd_valid: flush wins and the update is dropped.
- Sweep counter is SETS_LOG2 bits. The terminal set is detected explicitly, with no reliance on wrap-around.

## Configuration
- BTB_GSHARE_EN defined: a separate pattern history table of 2**SETS_LOG2 CNT_BITS counters, indexed by set index XOR GHR[SETS_LOG2-1:0].
  - o_taken (when hit) = PHT counter MSB.
  - Each update that is not dropped adjusts the PHT entry at the index formed with the pre-update GHR, then shifts i_upd_taken into the LSB of the SETS_LOG2-bit GHR.
  - The PHT is swept to weakly not-taken (MSB=0, rest 1) during INIT.
  - Per-entry BTB counters are still maintained but do not drive o_taken.
- BTB_GSHARE_EN undefined: no PHT or GHR; o_taken comes from the BTB entry counter.

## Test plan
- Reset with SETS_LOG2=7: o_ready=0 for exactly 128 cycles, then 1. o_hit=0 for any PC throughout.
- Taken update pc=0x1000, target=0x2000. Next-cycle lookup of 0x1000: o_hit=1, o_target=0x2000, o_taken=1. A not-taken update at pc=0x1100 followed by its lookup gives o_hit=0.
- CNT_BITS=2, allocated entry: 3 not-taken updates → counter 00, o_taken=0. 4 taken updates → counter 11, stays 11.
- WAYS=2, three taken PCs mapping to one set: A, B, update-hit A, then C. C evicts B. A and C hit, B misses.
- Update issued in the same cycle as a lookup of the same PC: that lookup misses; the next cycle hits.
- i_flush after allocations: o_ready=0 for 128 cycles, all prior entries miss, and an update issued during the sweep is dropped.

Source files
------------

// File: rtl/riscv_core_btb_assoc.sv
// Set-associative BTB: tree-PLRU replacement, saturating direction counters and a sequential invalidation sweep.
// Define BTB_GSHARE_EN to take the predicted direction from a GHR-indexed pattern history table.
module riscv_core_btb_assoc #(
  parameter int PC_LEN    = 64,
  parameter int SETS_LOG2 = 7,
  parameter int WAYS      = 2,
  parameter int TAG_WIDTH = PC_LEN - SETS_LOG2 - 1,
  parameter int CNT_BITS  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  output logic              o_ready,
  input  logic [PC_LEN-1:0] i_if_pc,
  output logic              o_hit,
  output logic [PC_LEN-1:0] o_target,
  output logic              o_taken,
  input  logic              i_upd_valid,
  input  logic [PC_LEN-1:0] i_upd_pc,
  input  logic [PC_LEN-1:0] i_upd_target,
  input  logic              i_upd_taken
);

  localparam int SETS   = 1 << SETS_LOG2;
  localparam int LOG2W  = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LOG2W : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [CNT_BITS-1:0]  CNT_MAX     = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]  CNT_WEAK_T  = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [SETS_LOG2-1:0] LAST_SET    = SETS_LOG2'(SETS - 1);

  typedef enum logic {INIT, READY} btbState_t;

  btbState_t            r_state, w_stateNxt;
  logic [SETS_LOG2-1:0] r_sweepCnt, w_sweepNxt;

  logic [WAYS-1:0]      r_valid  [SETS];
  logic [PLRU_W-1:0]    r_plru   [SETS];
  logic [TAG_WIDTH-1:0] r_tag    [SETS][WAYS];
  logic [PC_LEN-1:0]    r_target [SETS][WAYS];
  logic [CNT_BITS-1:0]  r_cnt    [SETS][WAYS];

  logic [SETS_LOG2-1:0] w_ifIdx, w_updIdx;
  logic [TAG_WIDTH-1:0] w_ifTag, w_updTag;
  logic                 w_ready, w_updEn, w_write, w_unused;
  logic                 w_ifHit, w_ifTaken, w_updHit, w_freeAvail;
  logic [WAY_W-1:0]     w_ifWay, w_updWay, w_freeWay, w_plruWay, w_touchWay;
  logic [PLRU_W-1:0]    w_plruNxt;
  logic [CNT_BITS-1:0]  w_cntNxt;

  function automatic logic [CNT_BITS-1:0] satCount(input logic [CNT_BITS-1:0] cur, input logic up);
    satCount = cur;
    if (up && cur != CNT_MAX) satCount = cur + CNT_BITS'(1);
    else if (!up && cur != '0) satCount = cur - CNT_BITS'(1);
  endfunction

  assign w_ifIdx  = i_if_pc[SETS_LOG2:1];
  assign w_ifTag  = i_if_pc[PC_LEN-1:SETS_LOG2+1];
  assign w_updIdx = i_upd_pc[SETS_LOG2:1];
  assign w_updTag = i_upd_pc[PC_LEN-1:SETS_LOG2+1];
  assign w_unused = i_if_pc[0] ^ i_upd_pc[0];

  assign w_ready = (r_state == READY);
  assign w_updEn = i_upd_valid && w_ready && !i_flush;
  assign w_write = w_updEn && (w_updHit || i_upd_taken);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= INIT;
      r_sweepCnt <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_sweepCnt <= w_sweepNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    w_sweepNxt = r_sweepCnt;
    case (r_state)
      INIT: begin
        if (i_flush) begin
          w_sweepNxt = '0;
        end else if (r_sweepCnt == LAST_SET) begin
          w_stateNxt = READY;
          w_sweepNxt = '0;
        end else begin
          w_sweepNxt = r_sweepCnt + SETS_LOG2'(1);
        end
      end
      READY: begin
        if (i_flush) begin
          w_stateNxt = INIT;
          w_sweepNxt = '0;
        end
      end
      default: w_stateNxt = INIT;
    endcase
  end

  // Descending scans leave the lowest matching / lowest invalid way selected.
  always_comb begin
    w_ifHit = 1'b0;
    w_ifWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_ifIdx][w] && r_tag[w_ifIdx][w] == w_ifTag) begin
        w_ifHit = 1'b1;
        w_ifWay = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_updHit    = 1'b0;
    w_updWay    = '0;
    w_freeAvail = 1'b0;
    w_freeWay   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_updIdx][w] && r_tag[w_updIdx][w] == w_updTag) begin
        w_updHit = 1'b1;
        w_updWay = WAY_W'(w);
      end
      if (!r_valid[w_updIdx][w]) begin
        w_freeAvail = 1'b1;
        w_freeWay   = WAY_W'(w);
      end
    end
  end

  // Heap-ordered tree: node n lives at bit n-1, a 1 steers the victim walk right.
  always_comb begin
    int node;
    node = 1;
    for (int l = 0; l < LOG2W; l++) begin
      node = 2 * node + int'(r_plru[w_updIdx][node-1]);
    end
    w_plruWay = WAY_W'(node - WAYS);
  end

  assign w_touchWay = w_updHit ? w_updWay : (w_freeAvail ? w_freeWay : w_plruWay);

  always_comb begin
    int node;
    int dir;
    w_plruNxt = r_plru[w_updIdx];
    node      = 1;
    for (int l = 0; l < LOG2W; l++) begin
      dir                = (int'(w_touchWay) >> (LOG2W - 1 - l)) & 1;
      w_plruNxt[node-1]  = (dir == 0);
      node               = 2 * node + dir;
    end
  end

  assign w_cntNxt = satCount(r_cnt[w_updIdx][w_updWay], i_upd_taken);

`ifdef BTB_GSHARE_EN
  localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = {1'b0, {(CNT_BITS-1){1'b1}}};

  logic [CNT_BITS-1:0]  r_pht [SETS];
  logic [SETS_LOG2-1:0] r_ghr;
  logic [SETS_LOG2-1:0] w_phtIdx;

  assign w_phtIdx  = w_updIdx ^ r_ghr;
  assign w_ifTaken = r_pht[w_ifIdx ^ r_ghr][CNT_BITS-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ghr <= '0;
    else if (w_updEn) r_ghr <= SETS_LOG2'({r_ghr, i_upd_taken});
  end

  always_ff @(posedge i_clk) begin
    if (!w_ready) r_pht[r_sweepCnt] <= CNT_WEAK_NT;
    else if (w_updEn) r_pht[w_phtIdx] <= satCount(r_pht[w_phtIdx], i_upd_taken);
  end
`else
  assign w_ifTaken = r_cnt[w_ifIdx][w_ifWay][CNT_BITS-1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else if (!w_ready) begin
      r_valid[r_sweepCnt] <= '0;
      r_plru[r_sweepCnt]  <= '0;
    end else if (w_write) begin
      r_valid[w_updIdx][w_touchWay] <= 1'b1;
      r_plru[w_updIdx]              <= w_plruNxt;
    end
  end

  // Payload arrays carry no reset so they can map onto SRAM macros.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_target[w_updIdx][w_touchWay] <= i_upd_target;
      r_cnt[w_updIdx][w_touchWay]    <= w_updHit ? w_cntNxt : CNT_WEAK_T;
      if (!w_updHit) r_tag[w_updIdx][w_touchWay] <= w_updTag;
    end
  end

  assign o_ready  = w_ready;
  assign o_hit    = w_ready && w_ifHit;
  assign o_target = o_hit ? r_target[w_ifIdx][w_ifWay] : '0;
  assign o_taken  = o_hit && w_ifTaken;

endmodule
